// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: payout FSM states,
// denomination select encoding and default coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_MID = 2'd1,
        SEL_HI  = 2'd2
    } den_sel_t;

    localparam int DEF_DEN_HI  = 10;
    localparam int DEF_DEN_MID = 5;
    localparam int DEF_DEN_LO  = 1;

endpackage

// File: rtl/coin_stock_bank.sv
// Three per-denomination coin stock counters with a load port (any value)
// and a single decrement port, plus nonzero flags for coin selection.
module coin_stock_bank
    import vend_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load_en,
    input  logic [1:0]    i_load_sel,
    input  logic [SW-1:0] i_load_value,
    input  logic          i_dec_en,
    input  logic [1:0]    i_dec_sel,
    output logic [SW-1:0] o_stock_hi,
    output logic [SW-1:0] o_stock_mid,
    output logic [SW-1:0] o_stock_lo,
    output logic          o_nz_hi,
    output logic          o_nz_mid,
    output logic          o_nz_lo
);

    logic [SW-1:0] r_hi;
    logic [SW-1:0] r_mid;
    logic [SW-1:0] r_lo;

    // Counter update: load and decrement never coincide (IDLE vs EJECT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi  <= '0;
            r_mid <= '0;
            r_lo  <= '0;
        end else begin
            if (i_load_en) begin
                case (i_load_sel)
                    SEL_LO:  r_lo  <= i_load_value;
                    SEL_MID: r_mid <= i_load_value;
                    SEL_HI:  r_hi  <= i_load_value;
                    default: ;
                endcase
            end
            if (i_dec_en) begin
                case (i_dec_sel)
                    SEL_LO:  r_lo  <= r_lo  - SW'(1);
                    SEL_MID: r_mid <= r_mid - SW'(1);
                    SEL_HI:  r_hi  <= r_hi  - SW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign o_stock_hi  = r_hi;
    assign o_stock_mid = r_mid;
    assign o_stock_lo  = r_lo;
    assign o_nz_hi     = (r_hi  != '0);
    assign o_nz_mid    = (r_mid != '0);
    assign o_nz_lo     = (r_lo  != '0);

endmodule

// File: rtl/change_payout_sequencer.sv
// Greedy change payout: picks the largest affordable in-stock coin, drives
// its ejector until the sensor acknowledges, and repeats until nothing is
// owed. Short stock or a missing acknowledge parks the block in FAULT.
module change_payout_sequencer
    import vend_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SW          = 8,
    parameter int DEN_HI      = DEF_DEN_HI,
    parameter int DEN_MID     = DEF_DEN_MID,
    parameter int DEN_LO      = DEF_DEN_LO,
    parameter int ACK_TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] change_in,
    input  logic          stock_load,
    input  logic [1:0]    stock_sel,
    input  logic [SW-1:0] stock_value,
    input  logic          eject_ack,
    input  logic          fault_clear,
    output logic          eject_hi,
    output logic          eject_mid,
    output logic          eject_lo,
    output logic          busy,
    output logic          done,
    output logic          short_alarm,
    output logic          jam_alarm,
    output logic [DW-1:0] remaining,
    output logic [SW-1:0] stock_hi,
    output logic [SW-1:0] stock_mid,
    output logic [SW-1:0] stock_lo
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] L_HI  = DW'(DEN_HI);
    localparam logic [DW-1:0] L_MID = DW'(DEN_MID);
    localparam logic [DW-1:0] L_LO  = DW'(DEN_LO);

    state_t        r_state, w_nxt_state;
    den_sel_t      r_sel, w_nxt_sel;
    logic [TW-1:0] r_timer, w_nxt_timer;
    logic [DW-1:0] r_remaining, w_nxt_remaining;
    logic          r_eject_hi, r_eject_mid, r_eject_lo;
    logic          w_nxt_eject_hi, w_nxt_eject_mid, w_nxt_eject_lo;
    logic          r_busy, r_done, r_short, r_jam;
    logic          w_nxt_busy, w_nxt_done, w_nxt_short, w_nxt_jam;
    logic          w_load_en, w_dec_en;
    logic          w_nz_hi, w_nz_mid, w_nz_lo;

    function automatic logic [DW-1:0] den_of(input den_sel_t sel);
        case (sel)
            SEL_HI:  den_of = L_HI;
            SEL_MID: den_of = L_MID;
            default: den_of = L_LO;
        endcase
    endfunction

    coin_stock_bank #(.SW(SW)) u_bank (
        .clk          (clk),
        .rst          (rst),
        .i_load_en    (w_load_en),
        .i_load_sel   (stock_sel),
        .i_load_value (stock_value),
        .i_dec_en     (w_dec_en),
        .i_dec_sel    (r_sel),
        .o_stock_hi   (stock_hi),
        .o_stock_mid  (stock_mid),
        .o_stock_lo   (stock_lo),
        .o_nz_hi      (w_nz_hi),
        .o_nz_mid     (w_nz_mid),
        .o_nz_lo      (w_nz_lo)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next-state, coin selection, timeout and next output values.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_sel       = r_sel;
        w_nxt_timer     = r_timer;
        w_nxt_remaining = r_remaining;
        w_nxt_eject_hi  = 1'b0;
        w_nxt_eject_mid = 1'b0;
        w_nxt_eject_lo  = 1'b0;
        w_nxt_done      = 1'b0;
        w_nxt_short     = r_short;
        w_nxt_jam       = r_jam;
        w_load_en       = 1'b0;
        w_dec_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_en = stock_load;
                if (start) begin
                    w_nxt_remaining = change_in;
                    w_nxt_state     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                w_nxt_timer = '0;
                if (r_remaining == '0) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_state = ST_DONE;
                end else if (L_HI <= r_remaining && w_nz_hi) begin
                    w_nxt_sel      = SEL_HI;
                    w_nxt_eject_hi = 1'b1;
                    w_nxt_state    = ST_EJECT;
                end else if (L_MID <= r_remaining && w_nz_mid) begin
                    w_nxt_sel       = SEL_MID;
                    w_nxt_eject_mid = 1'b1;
                    w_nxt_state     = ST_EJECT;
                end else if (L_LO <= r_remaining && w_nz_lo) begin
                    w_nxt_sel      = SEL_LO;
                    w_nxt_eject_lo = 1'b1;
                    w_nxt_state    = ST_EJECT;
                end else begin
                    w_nxt_short = 1'b1;
                    w_nxt_state = ST_FAULT;
                end
            end
            ST_EJECT: begin
                if (eject_ack) begin
                    w_nxt_remaining = r_remaining - den_of(r_sel);
                    w_dec_en        = 1'b1;
                    w_nxt_timer     = '0;
                    w_nxt_state     = ST_SELECT;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    w_nxt_jam   = 1'b1;
                    w_nxt_timer = '0;
                    w_nxt_state = ST_FAULT;
                end else begin
                    w_nxt_eject_hi  = (r_sel == SEL_HI);
                    w_nxt_eject_mid = (r_sel == SEL_MID);
                    w_nxt_eject_lo  = (r_sel == SEL_LO);
                    w_nxt_timer     = r_timer + TW'(1);
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    w_nxt_short     = 1'b0;
                    w_nxt_jam       = 1'b0;
                    w_nxt_remaining = '0;
                    w_nxt_state     = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        w_nxt_busy = (w_nxt_state != ST_IDLE);
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= SEL_LO;
            r_timer     <= '0;
            r_remaining <= '0;
            r_eject_hi  <= 1'b0;
            r_eject_mid <= 1'b0;
            r_eject_lo  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_jam       <= 1'b0;
        end else begin
            r_sel       <= w_nxt_sel;
            r_timer     <= w_nxt_timer;
            r_remaining <= w_nxt_remaining;
            r_eject_hi  <= w_nxt_eject_hi;
            r_eject_mid <= w_nxt_eject_mid;
            r_eject_lo  <= w_nxt_eject_lo;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_short     <= w_nxt_short;
            r_jam       <= w_nxt_jam;
        end
    end

    assign eject_hi    = r_eject_hi;
    assign eject_mid   = r_eject_mid;
    assign eject_lo    = r_eject_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign short_alarm = r_short;
    assign jam_alarm   = r_jam;
    assign remaining   = r_remaining;

endmodule

// File: tb/tb_change_payout_sequencer.sv
// Directed bench for change_payout_sequencer: a table of payout scenarios
// with hand-computed coin counts and final state, plus sequences for
// ack timeout, asynchronous reset mid-eject and zero-change timing.
module tb_change_payout_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] change_in = '0;
    logic       stock_load = 1'b0;
    logic [1:0] stock_sel = '0;
    logic [7:0] stock_value = '0;
    logic       eject_ack = 1'b0;
    logic       fault_clear = 1'b0;
    logic       eject_hi, eject_mid, eject_lo;
    logic       busy, done, short_alarm, jam_alarm;
    logic [7:0] remaining, stock_hi, stock_mid, stock_lo;

    int total = 0;
    int bad   = 0;

    change_payout_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .change_in   (change_in),
        .stock_load  (stock_load),
        .stock_sel   (stock_sel),
        .stock_value (stock_value),
        .eject_ack   (eject_ack),
        .fault_clear (fault_clear),
        .eject_hi    (eject_hi),
        .eject_mid   (eject_mid),
        .eject_lo    (eject_lo),
        .busy        (busy),
        .done        (done),
        .short_alarm (short_alarm),
        .jam_alarm   (jam_alarm),
        .remaining   (remaining),
        .stock_hi    (stock_hi),
        .stock_mid   (stock_mid),
        .stock_lo    (stock_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi, mid, lo;       // initial stocks
        int chg;               // change_in
        int comb;              // load lo in the same cycle as start
        int c_hi, c_mid, c_lo; // expected coins ejected
        int exp_done;          // 1 = done, 0 = short fault
        int exp_rem;           // remaining at completion / fault
        int s_hi, s_mid, s_lo; // expected final stocks
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; stock_load = 1'b0; eject_ack = 1'b0; fault_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load(input int sel, input int val);
        stock_load = 1'b1;
        stock_sel = 2'(sel);
        stock_value = 8'(val);
        tick();
        stock_load = 1'b0;
    endtask

    function automatic int den(input int which);
        return (which == 2) ? 10 : (which == 1) ? 5 : 1;
    endfunction

    initial begin
        int n_hi, n_mid, n_lo, got_done, got_short, ended, onehot_bad, rem_bad, run_rem;
        int cnt;

        vecs[0] = '{5, 5, 5, 17, 0, 1, 1, 2, 1, 0, 4, 4, 3};
        vecs[1] = '{0, 1, 10, 12, 0, 0, 1, 7, 1, 0, 0, 0, 3};
        vecs[2] = '{1, 0, 2, 14, 0, 1, 0, 2, 0, 2, 0, 0, 0};
        vecs[3] = '{5, 5, 5, 0, 0, 0, 0, 0, 1, 0, 5, 5, 5};
        vecs[4] = '{3, 3, 3, 38, 0, 3, 1, 3, 1, 0, 0, 2, 0};
        vecs[5] = '{2, 2, 0, 9, 0, 0, 1, 0, 0, 4, 2, 1, 0};
        vecs[6] = '{0, 0, 0, 3, 0, 0, 0, 0, 0, 3, 0, 0, 0};
        vecs[7] = '{9, 0, 0, 20, 0, 2, 0, 0, 1, 0, 7, 0, 0};
        vecs[8] = '{0, 0, 3, 2, 1, 0, 0, 2, 1, 0, 0, 0, 1};

        // Reset state
        do_reset();
        chk("reset_ctrl", int'({eject_hi, eject_mid, eject_lo, busy, done, short_alarm, jam_alarm}), 0);
        chk("reset_rem", int'(remaining), 0);
        chk("reset_stock", int'(stock_hi) + int'(stock_mid) + int'(stock_lo), 0);

        // Table-driven payouts with immediate acknowledge
        for (int v = 0; v < 9; v++) begin
            do_reset();
            load(2, vecs[v].hi);
            load(1, vecs[v].mid);
            change_in = 8'(vecs[v].chg);
            if (vecs[v].comb != 0) begin
                stock_load = 1'b1; stock_sel = 2'd0; stock_value = 8'(vecs[v].lo);
                start = 1'b1;
                tick();
                stock_load = 1'b0; start = 1'b0;
            end else begin
                load(0, vecs[v].lo);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            n_hi = 0; n_mid = 0; n_lo = 0; got_done = 0; got_short = 0;
            ended = 0; onehot_bad = 0; rem_bad = 0; run_rem = vecs[v].chg;
            for (int c = 0; c < 300 && ended == 0; c++) begin
                tick();
                if (int'(eject_hi) + int'(eject_mid) + int'(eject_lo) > 1) onehot_bad++;
                if (eject_hi || eject_mid || eject_lo) begin
                    if (int'(remaining) != run_rem) rem_bad++;
                    if (eject_hi)  begin n_hi++;  run_rem -= den(2); end
                    else if (eject_mid) begin n_mid++; run_rem -= den(1); end
                    else begin n_lo++; run_rem -= den(0); end
                    eject_ack = 1'b1;
                end else begin
                    eject_ack = 1'b0;
                end
                if (done) begin got_done = 1; ended = 1; end
                if (short_alarm || jam_alarm) begin got_short = short_alarm; ended = 1; end
            end
            eject_ack = 1'b0;
            chk($sformatf("v%0d_finished", v), ended, 1);
            chk($sformatf("v%0d_coins_hi", v), n_hi, vecs[v].c_hi);
            chk($sformatf("v%0d_coins_mid", v), n_mid, vecs[v].c_mid);
            chk($sformatf("v%0d_coins_lo", v), n_lo, vecs[v].c_lo);
            chk($sformatf("v%0d_done", v), got_done, vecs[v].exp_done);
            chk($sformatf("v%0d_short", v), got_short, 1 - vecs[v].exp_done);
            chk($sformatf("v%0d_rem", v), int'(remaining), vecs[v].exp_rem);
            chk($sformatf("v%0d_stock_hi", v), int'(stock_hi), vecs[v].s_hi);
            chk($sformatf("v%0d_stock_mid", v), int'(stock_mid), vecs[v].s_mid);
            chk($sformatf("v%0d_stock_lo", v), int'(stock_lo), vecs[v].s_lo);
            chk($sformatf("v%0d_onehot", v), onehot_bad, 0);
            chk($sformatf("v%0d_rem_track", v), rem_bad, 0);
            if (vecs[v].exp_done != 0) begin
                tick();
                chk($sformatf("v%0d_done_pulse", v), int'({done, busy}), 0);
            end else begin
                tick();
                chk($sformatf("v%0d_fault_hold", v), int'({done, busy, short_alarm}), 3'b011);
                fault_clear = 1'b1;
                tick();
                fault_clear = 1'b0;
                chk($sformatf("v%0d_clear", v), int'({done, busy, short_alarm, jam_alarm}), 0);
                chk($sformatf("v%0d_clear_rem", v), int'(remaining), 0);
            end
        end

        // Zero change: done exactly on the third cycle counting the start cycle
        do_reset();
        load(1, 4);
        change_in = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_c1", int'({done, busy, eject_hi, eject_mid, eject_lo}), 5'b01000);
        tick();
        chk("zero_c2", int'({done, busy, eject_hi, eject_mid, eject_lo}), 5'b11000);
        tick();
        chk("zero_c3", int'({done, busy, eject_hi, eject_mid, eject_lo}), 5'b00000);

        // Ack withheld: jam after ACK_TIMEOUT cycles of eject
        do_reset();
        load(2, 5);
        change_in = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        ended = 0;
        for (int c = 0; c < 400 && ended == 0; c++) begin
            tick();
            if (eject_hi) cnt++;
            if (jam_alarm) ended = 1;
        end
        chk("jam_seen", ended, 1);
        chk("jam_eject_cycles", cnt, 200);
        chk("jam_outputs", int'({eject_hi, eject_mid, eject_lo, busy, short_alarm}), 5'b00010);
        chk("jam_rem", int'(remaining), 10);
        chk("jam_stock", int'(stock_hi), 5);
        // start and stock_load ignored in FAULT
        stock_load = 1'b1; stock_sel = 2'd2; stock_value = 8'd77;
        start = 1'b1; change_in = 8'd3;
        tick();
        stock_load = 1'b0; start = 1'b0;
        tick();
        chk("fault_ignore_load", int'(stock_hi), 5);
        chk("fault_ignore_start", int'({jam_alarm, busy, eject_hi}), 3'b110);
        chk("fault_ignore_rem", int'(remaining), 10);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("jam_clear", int'({jam_alarm, busy, done}), 0);
        chk("jam_clear_rem", int'(remaining), 0);

        // Load while busy ignored, then asynchronous reset mid-eject
        do_reset();
        load(2, 5); load(1, 5); load(0, 5);
        change_in = 8'd17;
        start = 1'b1;
        tick();
        start = 1'b0;
        ended = 0;
        for (int c = 0; c < 10 && ended == 0; c++) begin
            tick();
            if (eject_hi) ended = 1;
        end
        chk("busy_eject_seen", ended, 1);
        stock_load = 1'b1; stock_sel = 2'd0; stock_value = 8'd99;
        tick();
        stock_load = 1'b0;
        chk("busy_load_ignored", int'(stock_lo), 5);
        chk("busy_eject_held", int'({eject_hi, busy}), 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctrl", int'({eject_hi, eject_mid, eject_lo, busy, done, short_alarm, jam_alarm}), 0);
        chk("async_rst_rem", int'(remaining), 0);
        chk("async_rst_stock", int'(stock_hi) + int'(stock_mid) + int'(stock_lo), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", int'({busy, eject_hi}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
